// File: rtl/usb3_link_pkg.sv
// Shared link-layer constants: K symbols, LTSSM encodings, LCW field positions,
// CRC polynomials/seeds and the header-packet framer state type.
package usb3_link_pkg;

    localparam logic [7:0] K_SHP = 8'hFB;
    localparam logic [7:0] K_EPF = 8'hF7;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;

    localparam logic [4:0] ST_U0 = 5'd16;
    localparam logic [4:0] ST_U1 = 5'd17;
    localparam logic [4:0] ST_U2 = 5'd18;
    localparam logic [4:0] ST_U3 = 5'd19;

    localparam int LCW_HSEQ_LSB  = 0;
    localparam int LCW_HUB_LSB   = 6;
    localparam int LCW_DLY_BIT   = 9;
    localparam int LCW_DEF_BIT   = 10;
    localparam int LCW_CRC5_LSB  = 11;

    localparam logic [15:0] CRC16_POLY = 16'h100B;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [4:0]  CRC5_POLY  = 5'h05;
    localparam logic [4:0]  CRC5_INIT  = 5'h1F;

    localparam logic [31:0] HPSTART_DATA = {K_SHP, K_SHP, K_SHP, K_EPF};
    localparam logic [3:0]  HPSTART_K    = 4'b1111;

    typedef enum logic [2:0] {
        HP_IDLE = 3'd0,
        HP_HDR0 = 3'd1,
        HP_HDR1 = 3'd2,
        HP_HDR2 = 3'd3,
        HP_LCW  = 3'd4
    } hp_state_e;

    function automatic logic is_hpstart(input logic [31:0] data, input logic [3:0] datak);
        return (datak == HPSTART_K) && (data == HPSTART_DATA);
    endfunction

endpackage

// File: rtl/usb3_link_hp_rx_if.sv
// Link-input stream and header-packet result bundle for the HP receive framer.
interface usb3_link_hp_rx_if;

    logic [4:0]  ltssm_state;
    logic [31:0] in_data;
    logic [3:0]  in_datak;
    logic        in_active;
    logic        hp_valid;
    logic [95:0] hp_header;
    logic [10:0] hp_lcw;
    logic        hp_crc16_ok;
    logic        hp_crc5_ok;
    logic        hp_abort;

    modport master (
        output ltssm_state, in_data, in_datak, in_active,
        input  hp_valid, hp_header, hp_lcw, hp_crc16_ok, hp_crc5_ok, hp_abort
    );

    modport slave (
        input  ltssm_state, in_data, in_datak, in_active,
        output hp_valid, hp_header, hp_lcw, hp_crc16_ok, hp_crc5_ok, hp_abort
    );

endinterface

// File: rtl/usb3_crc_hp.sv
// Combinational CRC engine for header packets: one DWORD of CRC-16 per cycle,
// plus the finalised (inverted, bit-reversed) CRC-16 and CRC-5 of the LCW.
module usb3_crc_hp
    import usb3_link_pkg::*;
(
    input  logic [15:0] crc16_cur,
    input  logic [31:0] data,
    input  logic [10:0] lcw,
    output logic [15:0] crc16_next,
    output logic [15:0] crc16_tx,
    output logic [4:0]  crc5_tx
);

    // Bytes go out in wire order (bits 31:24 first), each byte LSB first.
    function automatic logic [15:0] crc16_dw(input logic [15:0] c, input logic [31:0] d);
        logic [15:0] r;
        logic [31:0] dd;
        logic [7:0]  b;
        logic        fb;
        r  = c;
        dd = d;
        for (int i = 0; i < 4; i++) begin
            b  = dd[31:24];
            dd = {dd[23:0], 8'h00};
            for (int j = 0; j < 8; j++) begin
                fb = r[15] ^ b[0];
                b  = {1'b0, b[7:1]};
                r  = {r[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
            end
        end
        return r;
    endfunction

    function automatic logic [4:0] crc5_lcw(input logic [10:0] l);
        logic [4:0]  r;
        logic [10:0] ll;
        logic        fb;
        r  = CRC5_INIT;
        ll = l;
        for (int j = 0; j < 11; j++) begin
            fb = r[4] ^ ll[0];
            ll = {1'b0, ll[10:1]};
            r  = {r[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'h00);
        end
        return r;
    endfunction

    function automatic logic [15:0] rev16(input logic [15:0] x);
        logic [15:0] o;
        logic [15:0] t;
        o = 16'h0000;
        t = x;
        for (int j = 0; j < 16; j++) begin
            o = {o[14:0], t[0]};
            t = {1'b0, t[15:1]};
        end
        return o;
    endfunction

    function automatic logic [4:0] rev5(input logic [4:0] x);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    assign crc16_next = crc16_dw(crc16_cur, data);
    assign crc16_tx   = rev16(~crc16_cur);
    assign crc5_tx    = rev5(~crc5_lcw(lcw));

endmodule

// File: rtl/usb3_link_hp_rx.sv
// Header-packet receive framer: HPSTART detect, 3 header DWORDs + LCW capture, CRC checks.
// Optional saturating good/bad packet counters when USB3_HP_RX_STATS_EN is defined.
module usb3_link_hp_rx
    import usb3_link_pkg::*;
(
    input  logic local_clk,
    input  logic reset,
    usb3_link_hp_rx_if.slave link
`ifdef USB3_HP_RX_STATS_EN
    ,
    output logic [15:0] stat_good,
    output logic [15:0] stat_bad
`endif
);

    hp_state_e   state_r, state_s;
    logic [15:0] crc16_r, crc16_s, crc16_nxt_s, crc16_tx_s;
    logic [4:0]  crc5_tx_s;
    logic [95:0] hdr_r;
    logic        hpstart_s, u0_s, capture_s, done_s, abort_s;
    logic        hp_valid_r, hp_abort_r, crc16_ok_r, crc5_ok_r;
    logic [95:0] hp_header_r;
    logic [10:0] hp_lcw_r;

    assign hpstart_s = is_hpstart(link.in_data, link.in_datak);
    assign u0_s      = (link.ltssm_state == ST_U0);

    usb3_crc_hp u_crc (
        .crc16_cur  (crc16_r),
        .data       (link.in_data),
        .lcw        (link.in_data[10:0]),
        .crc16_next (crc16_nxt_s),
        .crc16_tx   (crc16_tx_s),
        .crc5_tx    (crc5_tx_s)
    );

    // Framer next-state; holes (in_active low) leave everything untouched.
    always_comb begin
        state_s   = state_r;
        crc16_s   = crc16_r;
        capture_s = 1'b0;
        done_s    = 1'b0;
        abort_s   = 1'b0;
        if (!link.in_active) begin
            state_s = state_r;
        end else if (state_r == HP_IDLE) begin
            if (hpstart_s && u0_s) begin
                state_s = HP_HDR0;
                crc16_s = CRC16_INIT;
            end else begin
                state_s = HP_IDLE;
            end
        end else if (!u0_s) begin
            abort_s = 1'b1;
            state_s = HP_IDLE;
        end else if (link.in_datak != 4'b0000) begin
            abort_s = 1'b1;
            if (hpstart_s) begin
                state_s = HP_HDR0;
                crc16_s = CRC16_INIT;
            end else begin
                state_s = HP_IDLE;
            end
        end else begin
            case (state_r)
                HP_HDR0: begin state_s = HP_HDR1; crc16_s = crc16_nxt_s; capture_s = 1'b1; end
                HP_HDR1: begin state_s = HP_HDR2; crc16_s = crc16_nxt_s; capture_s = 1'b1; end
                HP_HDR2: begin state_s = HP_LCW;  crc16_s = crc16_nxt_s; capture_s = 1'b1; end
                HP_LCW:  begin state_s = HP_IDLE; done_s = 1'b1; end
                default: begin state_s = HP_IDLE; end
            endcase
        end
    end

    // State and running CRC-16 registers.
    always_ff @(posedge local_clk or posedge reset) begin
        if (reset) begin
            state_r <= HP_IDLE;
            crc16_r <= CRC16_INIT;
        end else begin
            state_r <= state_s;
            crc16_r <= crc16_s;
        end
    end

    // Header DWORD capture, slot chosen by the state that accepted it.
    always_ff @(posedge local_clk or posedge reset) begin
        if (reset) begin
            hdr_r <= 96'h0;
        end else if (capture_s) begin
            case (state_r)
                HP_HDR0: hdr_r[95:64] <= link.in_data;
                HP_HDR1: hdr_r[63:32] <= link.in_data;
                HP_HDR2: hdr_r[31:0]  <= link.in_data;
                default: hdr_r        <= hdr_r;
            endcase
        end else begin
            hdr_r <= hdr_r;
        end
    end

    // Registered result outputs; pulses clear every cycle, packet fields hold.
    always_ff @(posedge local_clk or posedge reset) begin
        if (reset) begin
            hp_valid_r  <= 1'b0;
            hp_abort_r  <= 1'b0;
            hp_header_r <= 96'h0;
            hp_lcw_r    <= 11'h000;
            crc16_ok_r  <= 1'b0;
            crc5_ok_r   <= 1'b0;
        end else begin
            hp_valid_r <= done_s;
            hp_abort_r <= abort_s;
            if (done_s) begin
                hp_header_r <= hdr_r;
                hp_lcw_r    <= link.in_data[10:0];
                crc16_ok_r  <= (crc16_tx_s == link.in_data[31:16]);
                crc5_ok_r   <= (crc5_tx_s == link.in_data[15:11]);
            end else begin
                hp_header_r <= hp_header_r;
                hp_lcw_r    <= hp_lcw_r;
                crc16_ok_r  <= crc16_ok_r;
                crc5_ok_r   <= crc5_ok_r;
            end
        end
    end

    assign link.hp_valid    = hp_valid_r;
    assign link.hp_abort    = hp_abort_r;
    assign link.hp_header   = hp_header_r;
    assign link.hp_lcw      = hp_lcw_r;
    assign link.hp_crc16_ok = crc16_ok_r;
    assign link.hp_crc5_ok  = crc5_ok_r;

`ifdef USB3_HP_RX_STATS_EN
    logic [15:0] stat_good_r, stat_bad_r;
    logic        good_evt_s, bad_evt_s;

    assign good_evt_s = hp_valid_r && crc16_ok_r && crc5_ok_r;
    assign bad_evt_s  = (hp_valid_r && !(crc16_ok_r && crc5_ok_r)) || hp_abort_r;

    // Saturating good/bad packet counters.
    always_ff @(posedge local_clk or posedge reset) begin
        if (reset) begin
            stat_good_r <= 16'h0000;
            stat_bad_r  <= 16'h0000;
        end else begin
            if (good_evt_s && (stat_good_r != 16'hFFFF)) begin
                stat_good_r <= stat_good_r + 16'd1;
            end else begin
                stat_good_r <= stat_good_r;
            end
            if (bad_evt_s && (stat_bad_r != 16'hFFFF)) begin
                stat_bad_r <= stat_bad_r + 16'd1;
            end else begin
                stat_bad_r <= stat_bad_r;
            end
        end
    end

    assign stat_good = stat_good_r;
    assign stat_bad  = stat_bad_r;
`endif

endmodule

// File: tb/tb_usb3_link_hp_rx.sv
// Self-checking bench for usb3_link_hp_rx: directed test-plan scenarios plus
// randomized traffic, all compared every cycle against a packet-level model.
module tb_usb3_link_hp_rx;

    localparam logic [4:0]  U0    = 5'd16;
    localparam logic [4:0]  U1    = 5'd17;
    localparam logic [31:0] START = 32'hFBFBFBF7;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   n_valid  = 0;
    int   n_abort  = 0;
    int   valid_cycs[$];

    usb3_link_hp_rx_if bus();

`ifdef USB3_HP_RX_STATS_EN
    logic [15:0] stat_good, stat_bad;
    logic [15:0] exp_good, exp_bad;
`endif

    usb3_link_hp_rx dut (
        .local_clk (clk),
        .reset     (reset),
        .link      (bus)
`ifdef USB3_HP_RX_STATS_EN
        ,
        .stat_good (stat_good),
        .stat_bad  (stat_bad)
`endif
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    function automatic logic [15:0] m_rev16(input logic [15:0] x);
        logic [15:0] o;
        for (int j = 0; j < 16; j++) o[15-j] = x[j];
        return o;
    endfunction

    // CRC-16 of the first nbytes bytes of msg (taken from the top), as a serial bit stream.
    function automatic logic [15:0] m_crc16_raw(input logic [95:0] msg, input int nbytes);
        bit          bits[$];
        logic [7:0]  by;
        logic [15:0] r;
        r = 16'hFFFF;
        for (int i = 0; i < nbytes; i++) begin
            by = msg[95-8*i -: 8];
            for (int j = 0; j < 8; j++) bits.push_back(by[j]);
        end
        foreach (bits[i]) begin
            if (r[15] ^ bits[i]) r = (r << 1) ^ 16'h100B;
            else                 r = r << 1;
        end
        return r;
    endfunction

    function automatic logic [15:0] m_crc16_tx(input logic [95:0] hdr);
        return m_rev16(~m_crc16_raw(hdr, 12));
    endfunction

    function automatic logic [4:0] m_crc5_tx(input logic [10:0] l);
        logic [4:0] r, o;
        r = 5'h1F;
        for (int j = 0; j < 11; j++) begin
            if (r[4] ^ l[j]) r = (r << 1) ^ 5'h05;
            else             r = r << 1;
        end
        r = ~r;
        for (int j = 0; j < 5; j++) o[4-j] = r[j];
        return o;
    endfunction

    function automatic logic [31:0] mk_lcw(input logic [95:0] hdr, input logic [10:0] l);
        return {m_crc16_tx(hdr), m_crc5_tx(l), l};
    endfunction

    logic [31:0] m_words[$];
    logic        m_busy;
    logic        exp_valid, exp_abort, exp_ok16, exp_ok5;
    logic [95:0] exp_hdr;
    logic [10:0] exp_lcw;

    // Model: collect accepted DWORDs after HPSTART; the 4th completes a packet.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy    <= 1'b0;
            m_words.delete();
            exp_valid <= 1'b0;
            exp_abort <= 1'b0;
            exp_ok16  <= 1'b0;
            exp_ok5   <= 1'b0;
            exp_hdr   <= 96'h0;
            exp_lcw   <= 11'h0;
`ifdef USB3_HP_RX_STATS_EN
            exp_good  <= 16'h0;
            exp_bad   <= 16'h0;
`endif
        end else begin
`ifdef USB3_HP_RX_STATS_EN
            if (exp_valid && exp_ok16 && exp_ok5 && exp_good != 16'hFFFF) exp_good <= exp_good + 16'd1;
            if (((exp_valid && !(exp_ok16 && exp_ok5)) || exp_abort) && exp_bad != 16'hFFFF)
                exp_bad <= exp_bad + 16'd1;
`endif
            exp_valid <= 1'b0;
            exp_abort <= 1'b0;
            if (bus.in_active) begin
                if (!m_busy) begin
                    if (bus.in_datak == 4'hF && bus.in_data == START && bus.ltssm_state == U0) begin
                        m_busy <= 1'b1;
                        m_words.delete();
                    end
                end else if (bus.ltssm_state != U0) begin
                    exp_abort <= 1'b1;
                    m_busy    <= 1'b0;
                end else if (bus.in_datak != 4'h0) begin
                    exp_abort <= 1'b1;
                    m_busy    <= (bus.in_datak == 4'hF && bus.in_data == START);
                    m_words.delete();
                end else begin
                    m_words.push_back(bus.in_data);
                    if (m_words.size() == 4) begin
                        exp_valid <= 1'b1;
                        exp_hdr   <= {m_words[0], m_words[1], m_words[2]};
                        exp_lcw   <= m_words[3][10:0];
                        exp_ok16  <= (m_crc16_tx({m_words[0], m_words[1], m_words[2]}) == m_words[3][31:16]);
                        exp_ok5   <= (m_crc5_tx(m_words[3][10:0]) == m_words[3][15:11]);
                        m_busy    <= 1'b0;
                        m_words.delete();
                    end
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        chk("hp_valid", bus.hp_valid, exp_valid);
        chk("hp_abort", bus.hp_abort, exp_abort);
        chk("hp_header", bus.hp_header, exp_hdr);
        chk("hp_lcw", bus.hp_lcw, exp_lcw);
        chk("hp_crc16_ok", bus.hp_crc16_ok, exp_ok16);
        chk("hp_crc5_ok", bus.hp_crc5_ok, exp_ok5);
`ifdef USB3_HP_RX_STATS_EN
        chk("stat_good", stat_good, exp_good);
        chk("stat_bad", stat_bad, exp_bad);
`endif
        if (bus.hp_valid) begin
            n_valid++;
            valid_cycs.push_back(cyc);
        end
        if (bus.hp_abort) n_abort++;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic act, input logic [4:0] st);
        bus.in_data     = d;
        bus.in_datak    = k;
        bus.in_active   = act;
        bus.ltssm_state = st;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(32'h0, 4'h0, 1'b0, U0);
    endtask

    task automatic send_pkt(input logic [95:0] h, input logic [31:0] lw);
        drive(START, 4'hF, 1'b1, U0);
        drive(h[95:64], 4'h0, 1'b1, U0);
        drive(h[63:32], 4'h0, 1'b1, U0);
        drive(h[31:0], 4'h0, 1'b1, U0);
        drive(lw, 4'h0, 1'b1, U0);
    endtask

    logic [95:0] h_good, h_b, hr;
    logic [31:0] lw_good, lw_b, w[5];
    logic [10:0] lr;
    int          va0, ab0, ab_at, kind;

    initial begin
        reset = 1'b1;
        bus.in_data = 32'h0; bus.in_datak = 4'h0; bus.in_active = 1'b0; bus.ltssm_state = U0;

        // Pin the model with hand-computed values.
        chk("model_rev16", m_rev16(16'h0001), 16'h8000);
        chk("model_crc16_byte00", m_crc16_raw(96'h0, 1), 16'hF990);
        chk("model_crc5_lcw3", m_crc5_tx(11'd3), 5'h0A);

        idle(3);
        chk("reset_valid", bus.hp_valid, 1'b0);
        chk("reset_abort", bus.hp_abort, 1'b0);
        chk("reset_header", bus.hp_header, 96'h0);
        chk("reset_lcw", bus.hp_lcw, 11'h0);
        reset = 1'b0;
        idle(2);

        // Good packet.
        h_good  = 96'h00000008_00000000_00000000;
        lw_good = mk_lcw(h_good, 11'd3);
        send_pkt(h_good, lw_good);
        chk("good_valid", bus.hp_valid, 1'b1);
        chk("good_header", bus.hp_header, 96'h00000008_00000000_00000000);
        chk("good_hseq", bus.hp_lcw[2:0], 3'd3);
        chk("good_crc16_ok", bus.hp_crc16_ok, 1'b1);
        chk("good_crc5_ok", bus.hp_crc5_ok, 1'b1);
        idle(2);

        // Corrupt header DW1 bit 0, then LCW bit 1.
        send_pkt(h_good ^ 96'h00000000_00000001_00000000, lw_good);
        chk("bad16_valid", bus.hp_valid, 1'b1);
        chk("bad16_crc16_ok", bus.hp_crc16_ok, 1'b0);
        chk("bad16_crc5_ok", bus.hp_crc5_ok, 1'b1);
        idle(1);
        send_pkt(h_good, lw_good ^ 32'h0000_0002);
        chk("bad5_valid", bus.hp_valid, 1'b1);
        chk("bad5_crc16_ok", bus.hp_crc16_ok, 1'b1);
        chk("bad5_crc5_ok", bus.hp_crc5_ok, 1'b0);
        idle(2);

        // Holes between HDR1 and HDR2.
        drive(START, 4'hF, 1'b1, U0);
        drive(h_good[95:64], 4'h0, 1'b1, U0);
        drive(h_good[63:32], 4'h0, 1'b1, U0);
        drive(START, 4'hF, 1'b0, U0);
        drive(32'hDEADBEEF, 4'h8, 1'b0, U1);
        drive(32'h0, 4'h0, 1'b0, U0);
        drive(h_good[31:0], 4'h0, 1'b1, U0);
        chk("holes_no_early_valid", bus.hp_valid, 1'b0);
        drive(lw_good, 4'h0, 1'b1, U0);
        chk("holes_valid", bus.hp_valid, 1'b1);
        chk("holes_ok", {bus.hp_crc16_ok, bus.hp_crc5_ok}, 2'b11);
        idle(2);

        // Truncation restarted by a new HPSTART.
        h_b  = 96'h12345678_9ABCDEF0_0FEDCBA9;
        lw_b = mk_lcw(h_b, 11'h5C5);
        va0 = n_valid; ab0 = n_abort;
        drive(START, 4'hF, 1'b1, U0);
        drive(h_good[95:64], 4'h0, 1'b1, U0);
        drive(h_good[63:32], 4'h0, 1'b1, U0);
        send_pkt(h_b, lw_b);
        idle(2);
        chk("trunc_aborts", n_abort - ab0, 1);
        chk("trunc_valids", n_valid - va0, 1);
        chk("trunc_header", bus.hp_header, 96'h12345678_9ABCDEF0_0FEDCBA9);

        // LTSSM gating.
        va0 = n_valid; ab0 = n_abort;
        drive(START, 4'hF, 1'b1, U1);
        drive(h_good[95:64], 4'h0, 1'b1, U0);
        drive(h_good[63:32], 4'h0, 1'b1, U0);
        drive(h_good[31:0], 4'h0, 1'b1, U0);
        drive(lw_good, 4'h0, 1'b1, U0);
        idle(2);
        chk("gate_ignored", {n_valid - va0, n_abort - ab0}, 64'h0);
        drive(START, 4'hF, 1'b1, U0);
        drive(h_good[95:64], 4'h0, 1'b1, U0);
        drive(h_good[63:32], 4'h0, 1'b1, U1);
        chk("leave_u0_abort", bus.hp_abort, 1'b1);
        drive(h_good[31:0], 4'h0, 1'b1, U0);
        drive(lw_good, 4'h0, 1'b1, U0);
        idle(2);
        chk("leave_u0_aborts", n_abort - ab0, 1);
        chk("leave_u0_no_valid", n_valid - va0, 0);

        // Reset during HDR2, then back-to-back packets.
        drive(START, 4'hF, 1'b1, U0);
        drive(h_good[95:64], 4'h0, 1'b1, U0);
        drive(h_good[63:32], 4'h0, 1'b1, U0);
        va0 = n_valid; ab0 = n_abort;
        reset = 1'b1;
        drive(h_good[31:0], 4'h0, 1'b1, U0);
        drive(lw_good, 4'h0, 1'b1, U0);
        reset = 1'b0;
        valid_cycs.delete();
        send_pkt(h_good, lw_good);
        send_pkt(h_b, lw_b);
        idle(3);
        chk("rst_no_abort", n_abort - ab0, 0);
        chk("b2b_count", valid_cycs.size(), 2);
        if (valid_cycs.size() == 2) chk("b2b_gap", valid_cycs[1] - valid_cycs[0], 5);
`ifdef USB3_HP_RX_STATS_EN
        chk("stat_good_b2b", stat_good, 16'd2);
        chk("stat_bad_b2b", stat_bad, 16'd0);
`endif

        // Randomized traffic: holes, corruption, truncation, LTSSM exits.
        for (int p = 0; p < 300; p++) begin
            hr = {$urandom, $urandom, $urandom};
            lr = 11'($urandom);
            w[0] = START;
            w[1] = hr[95:64]; w[2] = hr[63:32]; w[3] = hr[31:0];
            w[4] = mk_lcw(hr, lr);
            if ($urandom_range(0, 3) == 0) begin
                kind = $urandom_range(1, 4);
                w[kind] = w[kind] ^ (32'h1 << $urandom_range(0, 31));
            end
            ab_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : -1;
            kind  = $urandom_range(0, 2);
            for (int i = 0; i < 5; i++) begin
                while ($urandom_range(0, 4) == 0)
                    drive($urandom, 4'($urandom), 1'b0, 5'($urandom));
                if (i == ab_at) begin
                    case (kind)
                        0: drive(START, 4'hF, 1'b1, U0);
                        1: drive($urandom, 4'($urandom_range(1, 15)), 1'b1, U0);
                        default: drive(w[i], 4'h0, 1'b1, U1);
                    endcase
                end else begin
                    drive(w[i], (i == 0) ? 4'hF : 4'h0, 1'b1,
                          ($urandom_range(0, 15) == 0 && i == 0) ? U1 : U0);
                end
            end
            for (int g = $urandom_range(0, 2); g > 0; g--)
                drive($urandom, 4'h0, 1'($urandom), U0);
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
